// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipelined control unit:
//   - RV32 base opcodes handled by the decoder
//   - ALU control codes and forwarding select codes
//   - control bundle carried through ID/EX, plus the trimmed MEM and WB
//     stage records carried through EX/MEM and MEM/WB
//   - small helpers for ALU-op selection and hazard source matching
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int CTRL_REG_AW = 5;
    localparam int CTRL_ALU_W  = 4;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [CTRL_ALU_W-1:0] ALU_AND    = 4'b0000;
    localparam logic [CTRL_ALU_W-1:0] ALU_OR     = 4'b0001;
    localparam logic [CTRL_ALU_W-1:0] ALU_ADD    = 4'b0010;
    localparam logic [CTRL_ALU_W-1:0] ALU_SLL    = 4'b0011;
    localparam logic [CTRL_ALU_W-1:0] ALU_SLT    = 4'b0100;
    localparam logic [CTRL_ALU_W-1:0] ALU_SLTU   = 4'b0101;
    localparam logic [CTRL_ALU_W-1:0] ALU_SUB    = 4'b0110;
    localparam logic [CTRL_ALU_W-1:0] ALU_SRL    = 4'b0111;
    localparam logic [CTRL_ALU_W-1:0] ALU_SRA    = 4'b1000;
    localparam logic [CTRL_ALU_W-1:0] ALU_PASS_B = 4'b1001;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic [CTRL_ALU_W-1:0]  alu_ctrl;
        logic                   alu_src;
        logic                   branch;
        logic                   jump;
        logic                   jump_return;
        logic                   as_byte;
        logic                   as_unsigned;
        logic [2:0]             b_type;
        logic                   mem_read;
        logic                   mem_write;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [CTRL_REG_AW-1:0] rd;
        logic [CTRL_REG_AW-1:0] rs1;
        logic [CTRL_REG_AW-1:0] rs2;
    } ctrl_bundle_t;

    typedef struct packed {
        logic                   mem_read;
        logic                   mem_write;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [CTRL_REG_AW-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [CTRL_REG_AW-1:0] rd;
    } wb_stage_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;
    localparam mem_stage_t   MEM_BUBBLE  = '0;
    localparam wb_stage_t    WB_BUBBLE   = '0;

    // ALU op from funct3/funct7[5]. Only register-register ops may select SUB;
    // OP-IMM has no subtract, but its shifts still honour funct7[5] (srai).
    // The ALU has no XOR code, so xor/xori fall back to ADD.
    function automatic logic [CTRL_ALU_W-1:0] alu_decode(
        input logic [2:0] funct3,
        input logic       funct7_b5,
        input logic       is_reg
    );
        logic [CTRL_ALU_W-1:0] op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // True when a non-zero destination matches any source the ID instruction
    // actually reads.
    function automatic logic src_hit(
        input logic [CTRL_REG_AW-1:0] rd,
        input logic [CTRL_REG_AW-1:0] rs1,
        input logic [CTRL_REG_AW-1:0] rs2,
        input logic                   rs1_used,
        input logic                   rs2_used
    );
        return (rd != '0) && ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
    endfunction

    function automatic mem_stage_t to_mem(input ctrl_bundle_t b);
        mem_stage_t m;
        m.mem_read   = b.mem_read;
        m.mem_write  = b.mem_write;
        m.reg_write  = b.reg_write;
        m.mem_to_reg = b.mem_to_reg;
        m.rd         = b.rd;
        return m;
    endfunction

    function automatic wb_stage_t to_wb(input mem_stage_t m);
        wb_stage_t w;
        w.reg_write  = m.reg_write;
        w.mem_to_reg = m.mem_to_reg;
        w.rd         = m.rd;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Purely combinational ID-stage decode of one instruction into a control
// bundle plus rs1/rs2 "used" flags for hazard detection.
//   instr        in   32  instruction held in IF/ID
//   instr_valid  in   1   0 forces a bubble
//   bundle       out  ctrl_bundle_t  decoded controls; rd/rs fields are zeroed
//                     when the instruction does not write/read them
//   rs1_used     out  1   instruction reads rs1
//   rs2_used     out  1   instruction reads rs2
// -----------------------------------------------------------------------------
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic         instr_valid,
    output ctrl_bundle_t bundle,
    output logic         rs1_used,
    output logic         rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    // Remaining funct7/immediate bits carry no control information.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        bundle   = CTRL_BUBBLE;
        rs1_used = 1'b0;
        rs2_used = 1'b0;

        if (instr_valid) begin
            case (opcode)
                OPC_RTYPE: begin
                    bundle.alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b1);
                    bundle.reg_write = 1'b1;
                    rs1_used         = 1'b1;
                    rs2_used         = 1'b1;
                end
                OPC_OPIMM: begin
                    bundle.alu_ctrl  = alu_decode(funct3, funct7_b5, 1'b0);
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                    rs1_used         = 1'b1;
                end
                OPC_LOAD: begin
                    bundle.alu_ctrl    = ALU_ADD;
                    bundle.alu_src     = 1'b1;
                    bundle.mem_read    = 1'b1;
                    bundle.reg_write   = 1'b1;
                    bundle.mem_to_reg  = 1'b1;
                    bundle.as_byte     = (funct3[1:0] == 2'b00);
                    bundle.as_unsigned = funct3[2];
                    rs1_used           = 1'b1;
                end
                OPC_STORE: begin
                    bundle.alu_ctrl  = ALU_ADD;
                    bundle.alu_src   = 1'b1;
                    bundle.mem_write = 1'b1;
                    bundle.as_byte   = (funct3[1:0] == 2'b00);
                    rs1_used         = 1'b1;
                    rs2_used         = 1'b1;
                end
                OPC_BRANCH: begin
                    bundle.alu_ctrl = ALU_SUB;
                    bundle.branch   = 1'b1;
                    bundle.b_type   = funct3;
                    rs1_used        = 1'b1;
                    rs2_used        = 1'b1;
                end
                OPC_JAL: begin
                    bundle.alu_ctrl  = ALU_ADD;
                    bundle.jump      = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_JALR: begin
                    bundle.alu_ctrl    = ALU_ADD;
                    bundle.alu_src     = 1'b1;
                    bundle.jump        = 1'b1;
                    bundle.jump_return = 1'b1;
                    bundle.reg_write   = 1'b1;
                    rs1_used           = 1'b1;
                end
                OPC_LUI: begin
                    bundle.alu_ctrl  = ALU_PASS_B;
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_AUIPC: begin
                    bundle.alu_ctrl  = ALU_ADD;
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                default: begin
                    bundle = CTRL_BUBBLE;
                end
            endcase
        end

        // Zeroed address fields keep hazard and forwarding compares honest
        // for operands the instruction never touches.
        bundle.rd  = bundle.reg_write ? instr[11:7]  : '0;
        bundle.rs1 = rs1_used         ? instr[19:15] : '0;
        bundle.rs2 = rs2_used         ? instr[24:20] : '0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined control: decodes the ID instruction, carries its controls through
// ID/EX, EX/MEM and MEM/WB, raises hazard stalls and inserts bubbles.
// Build option: PIPE_CTRL_FWD_EN
//   defined   - fwd_a/fwd_b select EX/MEM or MEM/WB results; only load-use
//               stalls
//   undefined - forwarding tied off; any RAW against ID/EX or EX/MEM stalls
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr, instr_valid    IF/ID instruction and its valid
//   stall_ext             external hold, freezes all control stages
//   flush                 squash ID (taken branch/jump in EX)
//   hazard_stall          hold PC and IF/ID this cycle
//   ex_*                  ID/EX controls for the EX stage
//   mem_read/mem_write/mem_rd     EX/MEM controls
//   wb_reg_write/wb_mem_to_reg/wb_rd  MEM/WB controls
//   fwd_a, fwd_b          00 regfile, 01 WB value, 10 MEM value
// -----------------------------------------------------------------------------
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = CTRL_REG_AW,
    parameter int ALUCTRL_W = CTRL_ALU_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    input  logic                 stall_ext,
    input  logic                 flush,
    output logic                 hazard_stall,
    output logic [ALUCTRL_W-1:0] ex_alu_ctrl,
    output logic                 ex_alu_src,
    output logic                 ex_branch,
    output logic                 ex_jump,
    output logic                 ex_jump_return,
    output logic                 ex_as_byte,
    output logic                 ex_as_unsigned,
    output logic [2:0]           ex_b_type,
    output logic [REG_AW-1:0]    ex_rs1,
    output logic [REG_AW-1:0]    ex_rs2,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [REG_AW-1:0]    mem_rd,
    output logic                 wb_reg_write,
    output logic                 wb_mem_to_reg,
    output logic [REG_AW-1:0]    wb_rd,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_bad
        $error("pipe_ctrl_unit: XLEN must be 32 or 64");
    end

    ctrl_bundle_t id_bundle;
    logic         id_rs1_used;
    logic         id_rs2_used;

    ctrl_bundle_t idex_q;
    mem_stage_t   exmem_q;
    wb_stage_t    memwb_q;

    logic load_use;
    logic hazard;

    ctrl_decode u_decode (
        .instr       (instr),
        .instr_valid (instr_valid),
        .bundle      (id_bundle),
        .rs1_used    (id_rs1_used),
        .rs2_used    (id_rs2_used)
    );

    assign load_use = idex_q.mem_read &&
                      src_hit(idex_q.rd, id_bundle.rs1, id_bundle.rs2,
                              id_rs1_used, id_rs2_used);

`ifdef PIPE_CTRL_FWD_EN
    assign hazard = load_use;
`else
    // Without forwarding, results are only visible once they leave MEM/WB
    // (write-before-read), so producers in ID/EX and EX/MEM must be waited on.
    assign hazard = load_use ||
                    (idex_q.reg_write &&
                     src_hit(idex_q.rd, id_bundle.rs1, id_bundle.rs2,
                             id_rs1_used, id_rs2_used)) ||
                    (exmem_q.reg_write &&
                     src_hit(exmem_q.rd, id_bundle.rs1, id_bundle.rs2,
                             id_rs1_used, id_rs2_used));
`endif

    // A flush discards the ID instruction anyway, so it cancels any stall.
    assign hazard_stall = stall_ext || (!flush && hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= CTRL_BUBBLE;
            exmem_q <= MEM_BUBBLE;
            memwb_q <= WB_BUBBLE;
        end else if (!stall_ext) begin
            exmem_q <= to_mem(idex_q);
            memwb_q <= to_wb(exmem_q);
            if (flush || hazard) begin
                idex_q <= CTRL_BUBBLE;
            end else begin
                idex_q <= id_bundle;
            end
        end
    end

`ifdef PIPE_CTRL_FWD_EN
    always_comb begin
        fwd_a = FWD_NONE;
        if (exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs1)) begin
            fwd_a = FWD_MEM;
        end else if (memwb_q.reg_write && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs1)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_NONE;
        if (exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == idex_q.rs2)) begin
            fwd_b = FWD_MEM;
        end else if (memwb_q.reg_write && (memwb_q.rd != '0) && (memwb_q.rd == idex_q.rs2)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    assign fwd_a = FWD_NONE;
    assign fwd_b = FWD_NONE;
`endif

    assign ex_alu_ctrl    = idex_q.alu_ctrl;
    assign ex_alu_src     = idex_q.alu_src;
    assign ex_branch      = idex_q.branch;
    assign ex_jump        = idex_q.jump;
    assign ex_jump_return = idex_q.jump_return;
    assign ex_as_byte     = idex_q.as_byte;
    assign ex_as_unsigned = idex_q.as_unsigned;
    assign ex_b_type      = idex_q.b_type;
    assign ex_rs1         = idex_q.rs1;
    assign ex_rs2         = idex_q.rs2;

    assign mem_read  = exmem_q.mem_read;
    assign mem_write = exmem_q.mem_write;
    assign mem_rd    = exmem_q.rd;

    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_rd         = memwb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        stall_ext = 1'b0;
    logic        flush = 1'b0;

    logic        hazard_stall;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src, ex_branch, ex_jump, ex_jump_return, ex_as_byte, ex_as_unsigned;
    logic [2:0]  ex_b_type;
    logic [4:0]  ex_rs1, ex_rs2;
    logic        mem_read, mem_write;
    logic [4:0]  mem_rd;
    logic        wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [1:0]  fwd_a, fwd_b;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;

    pipe_ctrl_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .stall_ext      (stall_ext),
        .flush          (flush),
        .hazard_stall   (hazard_stall),
        .ex_alu_ctrl    (ex_alu_ctrl),
        .ex_alu_src     (ex_alu_src),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_jump_return (ex_jump_return),
        .ex_as_byte     (ex_as_byte),
        .ex_as_unsigned (ex_as_unsigned),
        .ex_b_type      (ex_b_type),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_rd         (mem_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_mem_to_reg  (wb_mem_to_reg),
        .wb_rd          (wb_rd),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [6:0] op);
        return {20'h12345, rd, op};
    endfunction

    function automatic logic [48:0] all_outs();
        return {hazard_stall, ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump, ex_jump_return,
                ex_as_byte, ex_as_unsigned, ex_b_type, ex_rs1, ex_rs2, mem_read, mem_write,
                mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, fwd_a, fwd_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i);
        instr       = i;
        instr_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        instr       = '0;
        instr_valid = 1'b0;
        flush       = 1'b0;
        stall_ext   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL rst_init: outputs=%h expected 0", all_outs());
        end
        rst_n = 1'b1;
        tick();
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_rs1, ex_rs2} !== {4'b0010, 5'd1, 5'd2}) begin
            errors++;
            $display("FAIL rst_pre_add: alu/rs1/rs2=%b/%0d/%0d expected 0010/1/2",
                     ex_alu_ctrl, ex_rs1, ex_rs2);
        end
        issue(enc_u(5'd8, 7'b0110111));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL rst_async: outputs=%h expected 0", all_outs());
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_hazard: hazard_stall=%b expected 0", hazard_stall);
        end
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        idle(3);
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LD));
        tick();
        issue(enc_r(7'd0, 5'd2, 5'd5, 3'b000, 5'd6));
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: hazard_stall=%b expected 1", hazard_stall);
        end
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_rs1, mem_read, mem_rd} !== {4'b0000, 5'd0, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL lu_bubble: alu=%b rs1=%0d mem_read=%b mem_rd=%0d expected 0000/0/1/5",
                     ex_alu_ctrl, ex_rs1, mem_read, mem_rd);
        end
        #1;
`ifdef PIPE_CTRL_FWD_EN
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_release: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
`else
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_raw_mem: hazard_stall=%b expected 1", hazard_stall);
        end
        tick();
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_release: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
`endif
        checks++;
        if ({ex_alu_ctrl, ex_rs1, ex_rs2} !== {4'b0010, 5'd5, 5'd2}) begin
            errors++;
            $display("FAIL lu_add_ex: alu/rs1/rs2=%b/%0d/%0d expected 0010/5/2",
                     ex_alu_ctrl, ex_rs1, ex_rs2);
        end
        checks++;
`ifdef PIPE_CTRL_FWD_EN
        if ({fwd_a, fwd_b} !== {2'b01, 2'b00}) begin
            errors++;
            $display("FAIL lu_fwd: fwd_a/fwd_b=%b/%b expected 01/00", fwd_a, fwd_b);
        end
`else
        if ({fwd_a, fwd_b} !== {2'b00, 2'b00}) begin
            errors++;
            $display("FAIL lu_fwd: fwd_a/fwd_b=%b/%b expected 00/00", fwd_a, fwd_b);
        end
`endif
    endtask

    task automatic test_raw();
        idle(3);
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3));
        tick();
        issue(enc_r(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4));
        #1;
`ifdef PIPE_CTRL_FWD_EN
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_nostall: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
        checks++;
        if ({ex_alu_ctrl, fwd_a, fwd_b} !== {4'b0110, 2'b10, 2'b10}) begin
            errors++;
            $display("FAIL raw_fwd: alu=%b fwd_a=%b fwd_b=%b expected 0110/10/10",
                     ex_alu_ctrl, fwd_a, fwd_b);
        end
`else
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (hazard_stall !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall%0d: hazard_stall=%b expected 1", c, hazard_stall);
            end
            tick();
            #1;
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_rs1, ex_rs2, fwd_a, fwd_b} !== {4'b0110, 5'd3, 5'd3, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL raw_sub_ex: alu=%b rs1=%0d rs2=%0d fwd=%b/%b expected 0110/3/3/00/00",
                     ex_alu_ctrl, ex_rs1, ex_rs2, fwd_a, fwd_b);
        end
`endif
    endtask

    task automatic test_flush();
        idle(3);
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LD));
        tick();
        issue(enc_r(7'd0, 5'd2, 5'd5, 3'b000, 5'd6));
        flush = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL fl_stall: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_rs1, ex_rs2, mem_read, mem_rd} !== {4'b0000, 5'd0, 5'd0, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL fl_bubble: alu=%b rs1=%0d rs2=%0d mem_read=%b mem_rd=%0d expected 0000/0/0/1/5",
                     ex_alu_ctrl, ex_rs1, ex_rs2, mem_read, mem_rd);
        end
        flush       = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic test_stall_ext();
        idle(3);
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd9));
        tick();
        issue(enc_s(5'd2, 5'd1, 3'b010));
        tick();
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd7));
        tick();
        issue(enc_u(5'd8, 7'b0110111));
        stall_ext = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (hazard_stall !== 1'b1) begin
                errors++;
                $display("FAIL se_stall%0d: hazard_stall=%b expected 1", c, hazard_stall);
            end
            tick();
            checks++;
            if ({mem_write, mem_rd, wb_reg_write, wb_rd, ex_alu_ctrl, ex_rs1, ex_rs2} !==
                {1'b1, 5'd0, 1'b1, 5'd9, 4'b0010, 5'd1, 5'd2}) begin
                errors++;
                $display("FAIL se_hold%0d: mw=%b mem_rd=%0d wb_we=%b wb_rd=%0d alu=%b rs1=%0d rs2=%0d expected 1/0/1/9/0010/1/2",
                         c, mem_write, mem_rd, wb_reg_write, wb_rd, ex_alu_ctrl, ex_rs1, ex_rs2);
            end
        end
        stall_ext = 1'b0;
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src, ex_rs1} !== {4'b1001, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL lui_ex: alu=%b src=%b rs1=%0d expected 1001/1/0", ex_alu_ctrl, ex_alu_src, ex_rs1);
        end
        checks++;
        if ({mem_rd, mem_write, wb_rd, wb_reg_write} !== {5'd7, 1'b0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL se_release: mem_rd=%0d mw=%b wb_rd=%0d wb_we=%b expected 7/0/0/0",
                     mem_rd, mem_write, wb_rd, wb_reg_write);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_decode();
        idle(3);
        issue(enc_b(5'd2, 5'd1, 3'b111));
        tick();
        checks++;
        if ({ex_b_type, ex_alu_ctrl, ex_branch, ex_alu_src} !== {3'b111, 4'b0110, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dec_bgeu: b_type=%b alu=%b br=%b src=%b expected 111/0110/1/0",
                     ex_b_type, ex_alu_ctrl, ex_branch, ex_alu_src);
        end
        issue(enc_i({7'b0100000, 5'd2}, 5'd11, 3'b101, 5'd10, OP_I));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src, ex_rs1, ex_rs2, ex_branch} !== {4'b1000, 1'b1, 5'd11, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL dec_srai: alu=%b src=%b rs1=%0d rs2=%0d br=%b expected 1000/1/11/0/0",
                     ex_alu_ctrl, ex_alu_src, ex_rs1, ex_rs2, ex_branch);
        end
        issue(enc_r(7'd0, 5'd14, 5'd13, 3'b011, 5'd12));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src} !== {4'b0101, 1'b0}) begin
            errors++;
            $display("FAIL dec_sltu: alu=%b src=%b expected 0101/0", ex_alu_ctrl, ex_alu_src);
        end
        issue(enc_i(12'd5, 5'd1, 3'b010, 5'd20, OP_I));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src} !== {4'b0100, 1'b1}) begin
            errors++;
            $display("FAIL dec_slti: alu=%b src=%b expected 0100/1", ex_alu_ctrl, ex_alu_src);
        end
        issue(enc_i(12'd0, 5'd16, 3'b100, 5'd15, OP_LD));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src, ex_as_byte, ex_as_unsigned} !== {4'b0010, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL dec_lbu: alu=%b src=%b byte=%b uns=%b expected 0010/1/1/1",
                     ex_alu_ctrl, ex_alu_src, ex_as_byte, ex_as_unsigned);
        end
        issue(enc_i(12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111));
        tick();
        checks++;
        if ({ex_jump, ex_jump_return, ex_alu_src, ex_rs1, mem_read, mem_rd} !==
            {1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 5'd15}) begin
            errors++;
            $display("FAIL dec_jalr: j=%b jr=%b src=%b rs1=%0d mem_read=%b mem_rd=%0d expected 1/1/1/5/1/15",
                     ex_jump, ex_jump_return, ex_alu_src, ex_rs1, mem_read, mem_rd);
        end
        issue(enc_u(5'd1, 7'b1101111));
        tick();
        checks++;
        if ({ex_jump, ex_jump_return, ex_rs1, ex_rs2} !== {1'b1, 1'b0, 5'd0, 5'd0}) begin
            errors++;
            $display("FAIL dec_jal: j=%b jr=%b rs1=%0d rs2=%0d expected 1/0/0/0",
                     ex_jump, ex_jump_return, ex_rs1, ex_rs2);
        end
        issue(enc_u(5'd21, 7'b0010111));
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src, ex_jump} !== {4'b0010, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dec_auipc: alu=%b src=%b j=%b expected 0010/1/0", ex_alu_ctrl, ex_alu_src, ex_jump);
        end
        issue(32'h0000_0000);
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump, ex_jump_return, ex_as_byte,
             ex_as_unsigned, ex_b_type, ex_rs1, ex_rs2} !== '0) begin
            errors++;
            $display("FAIL dec_illegal: alu=%b src=%b br=%b j=%b rs1=%0d rs2=%0d expected all 0",
                     ex_alu_ctrl, ex_alu_src, ex_branch, ex_jump, ex_rs1, ex_rs2);
        end
        instr       = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        instr_valid = 1'b0;
        tick();
        checks++;
        if ({ex_alu_ctrl, ex_rs1, ex_rs2} !== '0) begin
            errors++;
            $display("FAIL dec_invalid: alu=%b rs1=%0d rs2=%0d expected 0/0/0", ex_alu_ctrl, ex_rs1, ex_rs2);
        end
    endtask

    task automatic test_x0();
        idle(3);
        issue(enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd0));
        tick();
        issue(enc_r(7'b0100000, 5'd0, 5'd0, 3'b000, 5'd4));
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: hazard_stall=%b expected 0", hazard_stall);
        end
        tick();
        checks++;
        if ({ex_alu_ctrl, fwd_a, fwd_b} !== {4'b0110, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL x0_fwd: alu=%b fwd_a=%b fwd_b=%b expected 0110/00/00", ex_alu_ctrl, fwd_a, fwd_b);
        end
        idle(3);
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd0, OP_LD));
        tick();
        issue(enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd6));
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_loaduse: hazard_stall=%b expected 0", hazard_stall);
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_raw();
        test_flush();
        test_stall_ext();
        test_decode();
        test_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
